// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order WB stage vs. out-of-band long-unit results.
// One-entry buffer absorbs a colliding long-unit result; an aged entry forces a one-cycle WB stall.
module wb_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int AGE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pipe_valid_i,
    input  logic [ADDR_W-1:0] pipe_rd_i,
    input  logic [DATA_W-1:0] pipe_data_i,
    input  logic              lu_valid_i,
    input  logic [ADDR_W-1:0] lu_rd_i,
    input  logic [DATA_W-1:0] lu_data_i,
    output logic              lu_ready_o,
    output logic              pipe_stall_o,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              pending_o,
    output logic [ADDR_W-1:0] pending_rd_o
);

    typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        age_q, age_d;
    logic [ADDR_W-1:0] buf_rd_q, buf_rd_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    wr_t               wr_q, wr_d;

    logic pipe_eff, lu_acc, lu_wr;

    // Handshake outputs come from registered state only; held low while reset is asserted.
    assign lu_ready_o   = rst_i && (state_q == IDLE);
    assign pipe_stall_o = rst_i && (state_q == FORCE);

    assign pipe_eff = pipe_valid_i && !pipe_stall_o && (pipe_rd_i != '0);
    assign lu_acc   = lu_valid_i && lu_ready_o;
    assign lu_wr    = lu_acc && (lu_rd_i != '0);

    assign pending_o    = (state_q != IDLE);
    assign pending_rd_o = pending_o ? buf_rd_q : '0;

    assign RegWrite_o = wr_q.en;
    assign wr_addr_o  = wr_q.addr;
    assign wr_data_o  = wr_q.data;

    always_comb begin
        state_d    = state_q;
        age_d      = age_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        wr_d       = '{en: 1'b0, addr: wr_q.addr, data: wr_q.data};

        unique case (state_q)
            IDLE: begin
                if (pipe_eff) begin
                    wr_d = '{en: 1'b1, addr: pipe_rd_i, data: pipe_data_i};
                    if (lu_wr) begin
                        buf_rd_d   = lu_rd_i;
                        buf_data_d = lu_data_i;
                        age_d      = '0;
                        state_d    = HOLD;
                    end
                end else if (lu_wr) begin
                    wr_d = '{en: 1'b1, addr: lu_rd_i, data: lu_data_i};
                end
            end
            HOLD: begin
                if (!pipe_eff) begin
                    wr_d       = '{en: 1'b1, addr: buf_rd_q, data: buf_data_q};
                    buf_rd_d   = '0;
                    buf_data_d = '0;
                    state_d    = IDLE;
                end else if (pipe_rd_i == buf_rd_q) begin
                    // Younger pipe write to the same register supersedes the buffered one.
                    wr_d       = '{en: 1'b1, addr: pipe_rd_i, data: pipe_data_i};
                    buf_rd_d   = '0;
                    buf_data_d = '0;
                    state_d    = IDLE;
                end else begin
                    wr_d  = '{en: 1'b1, addr: pipe_rd_i, data: pipe_data_i};
                    age_d = age_q + 4'd1;
                    if (age_d == AGE_LIM)
                        state_d = FORCE;
                end
            end
            FORCE: begin
                wr_d       = '{en: 1'b1, addr: buf_rd_q, data: buf_data_q};
                buf_rd_d   = '0;
                buf_data_d = '0;
                age_d      = '0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            age_q      <= '0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            age_q      <= age_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            wr_q       <= wr_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writes (addr, data, cycle) are queued as
// stimulus is driven and matched against RegWrite_o/wr_* on the falling edge.
module tb_wb_port_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int AGE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              pipe_valid_i = 1'b0;
    logic [ADDR_W-1:0] pipe_rd_i = '0;
    logic [DATA_W-1:0] pipe_data_i = '0;
    logic              lu_valid_i = 1'b0;
    logic [ADDR_W-1:0] lu_rd_i = '0;
    logic [DATA_W-1:0] lu_data_i = '0;
    logic              lu_ready_o, pipe_stall_o, RegWrite_o, pending_o;
    logic [ADDR_W-1:0] wr_addr_o, pending_rd_o;
    logic [DATA_W-1:0] wr_data_o;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AGE_MAX(AGE_MAX)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pipe_valid_i(pipe_valid_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
        .lu_ready_o(lu_ready_o), .pipe_stall_o(pipe_stall_o),
        .RegWrite_o(RegWrite_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .pending_o(pending_o), .pending_rd_o(pending_rd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write must match the head entry, and the head entry must land on its cycle.
    always @(negedge clk) begin
        if (RegWrite_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write cyc=%0d got r%0d=%h required no write", cyc, wr_addr_o, wr_data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wr_addr_o !== e.addr || wr_data_o !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL write cyc=%0d got r%0d=%h required r%0d=%h at cyc %0d",
                             cyc, wr_addr_o, wr_data_o, e.addr, e.data, e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_write cyc=%0d got RegWrite_o=%b required r%0d=%h at cyc %0d",
                     cyc, RegWrite_o, e.addr, e.data, e.cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int c);
        exp_t e;
        e.addr = a; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        pipe_valid_i = 1'b0; pipe_rd_i = '0; pipe_data_i = '0;
        lu_valid_i   = 1'b0; lu_rd_i   = '0; lu_data_i   = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd5; pipe_data_i = 32'h1111;
        lu_valid_i   = 1'b1; lu_rd_i   = 5'd6; lu_data_i   = 32'h2222;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (RegWrite_o !== 1'b0 || lu_ready_o !== 1'b0 || pipe_stall_o !== 1'b0 ||
                pending_o !== 1'b0 || pending_rd_o !== '0 || wr_addr_o !== '0 || wr_data_o !== '0) begin
                failures++;
                $display("FAIL reset_state got we=%b rdy=%b stall=%b pend=%b prd=%0d a=%0d d=%h required all 0",
                         RegWrite_o, lu_ready_o, pipe_stall_o, pending_o, pending_rd_o, wr_addr_o, wr_data_o);
            end
        end
        idle_inputs();
        rst_i = 1'b1;
        #1;
        checks++;
        if (lu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b required 1", lu_ready_o);
        end
        tick();
        checks++;
        if (RegWrite_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_write got RegWrite_o=%b required 0", RegWrite_o);
        end
    endtask

    task automatic test_pipe_only();
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd5; pipe_data_i = 32'h1234;
        expect_wr(5'd5, 32'h1234, cyc + 1);
        tick();
        idle_inputs();
        checks++;
        if (lu_ready_o !== 1'b1 || pending_o !== 1'b0) begin
            failures++;
            $display("FAIL pipe_only_state got rdy=%b pend=%b required rdy=1 pend=0", lu_ready_o, pending_o);
        end
        tick();
        checks++;
        if (RegWrite_o !== 1'b0 || wr_addr_o !== 5'd5 || wr_data_o !== 32'h1234) begin
            failures++;
            $display("FAIL pipe_only_hold got we=%b a=%0d d=%h required we=0 a=5 d=00001234",
                     RegWrite_o, wr_addr_o, wr_data_o);
        end
        // Pipe write to r0 is not a write.
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd0; pipe_data_i = 32'hBEEF;
        tick();
        idle_inputs();
    endtask

    task automatic test_bypass();
        lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_data_i = 32'hCAFE;
        expect_wr(5'd7, 32'hCAFE, cyc + 1);
        tick();
        idle_inputs();
        checks++;
        if (lu_ready_o !== 1'b1 || pending_o !== 1'b0) begin
            failures++;
            $display("FAIL bypass_state got rdy=%b pend=%b required rdy=1 pend=0", lu_ready_o, pending_o);
        end
        tick();
    endtask

    task automatic test_collision();
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'h3333;
        lu_valid_i   = 1'b1; lu_rd_i   = 5'd9; lu_data_i   = 32'h9999;
        expect_wr(5'd3, 32'h3333, cyc + 1);
        expect_wr(5'd9, 32'h9999, cyc + 2);
        tick();
        idle_inputs();
        checks++;
        if (pending_o !== 1'b1 || pending_rd_o !== 5'd9 || lu_ready_o !== 1'b0 || pipe_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL collision_hold got pend=%b prd=%0d rdy=%b stall=%b required 1 9 0 0",
                     pending_o, pending_rd_o, lu_ready_o, pipe_stall_o);
        end
        tick();
        checks++;
        if (pending_o !== 1'b0 || pending_rd_o !== '0 || lu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL collision_drain got pend=%b prd=%0d rdy=%b required 0 0 1",
                     pending_o, pending_rd_o, lu_ready_o);
        end
        tick();
    endtask

    task automatic test_aging();
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'h0300;
        lu_valid_i   = 1'b1; lu_rd_i   = 5'd9; lu_data_i   = 32'h0900;
        expect_wr(5'd3, 32'h0300, cyc + 1);
        tick();
        lu_valid_i = 1'b0;
        for (int r = 1; r <= AGE_MAX; r++) begin
            pipe_rd_i = 5'(r); pipe_data_i = 32'h100 * r;
            expect_wr(5'(r), 32'h100 * r, cyc + 1);
            checks++;
            if (pipe_stall_o !== 1'b0 || pending_o !== 1'b1) begin
                failures++;
                $display("FAIL aging_pre_stall win=%0d got stall=%b pend=%b required 0 1", r, pipe_stall_o, pending_o);
            end
            tick();
        end
        // Pipe presents r5; the stalled cycle drains r9, r5 lands a cycle later.
        pipe_rd_i = 5'd5; pipe_data_i = 32'h0500;
        checks++;
        if (pipe_stall_o !== 1'b1 || lu_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL aging_stall got stall=%b rdy=%b required 1 0", pipe_stall_o, lu_ready_o);
        end
        expect_wr(5'd9, 32'h0900, cyc + 1);
        tick();
        checks++;
        if (pipe_stall_o !== 1'b0 || pending_o !== 1'b0) begin
            failures++;
            $display("FAIL aging_release got stall=%b pend=%b required 0 0", pipe_stall_o, pending_o);
        end
        expect_wr(5'd5, 32'h0500, cyc + 1);
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_waw_rd0();
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'h0033;
        lu_valid_i   = 1'b1; lu_rd_i   = 5'd9; lu_data_i   = 32'h00AA;
        expect_wr(5'd3, 32'h0033, cyc + 1);
        tick();
        lu_valid_i = 1'b0;
        pipe_rd_i = 5'd9; pipe_data_i = 32'h0055;
        expect_wr(5'd9, 32'h0055, cyc + 1);
        tick();
        idle_inputs();
        checks++;
        if (pending_o !== 1'b0 || lu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL waw_drop got pend=%b rdy=%b required 0 1", pending_o, lu_ready_o);
        end
        tick();
        tick();
        // lu result to r0 is consumed silently.
        lu_valid_i = 1'b1; lu_rd_i = 5'd0; lu_data_i = 32'hDEAD;
        tick();
        idle_inputs();
        checks++;
        if (RegWrite_o !== 1'b0 || pending_o !== 1'b0 || lu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL lu_rd0 got we=%b pend=%b rdy=%b required 0 0 1", RegWrite_o, pending_o, lu_ready_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd4; pipe_data_i = 32'h4444;
        lu_valid_i   = 1'b1; lu_rd_i   = 5'd12; lu_data_i  = 32'hC0C0;
        expect_wr(5'd4, 32'h4444, cyc + 1);
        tick();
        idle_inputs();
        rst_i = 1'b0;
        #1;
        checks++;
        if (lu_ready_o !== 1'b0 || pipe_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_comb got rdy=%b stall=%b required 0 0", lu_ready_o, pipe_stall_o);
        end
        tick();
        rst_i = 1'b1;
        checks++;
        if (RegWrite_o !== 1'b0 || pending_o !== 1'b0 || pending_rd_o !== '0) begin
            failures++;
            $display("FAIL reset_mid got we=%b pend=%b prd=%0d required 0 0 0", RegWrite_o, pending_o, pending_rd_o);
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        // Alternating bypass and pipe writes, one per cycle.
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                lu_valid_i = 1'b1; lu_rd_i = 5'(16 + i); lu_data_i = 32'hA000 + i;
                expect_wr(5'(16 + i), 32'hA000 + i, cyc + 1);
            end else begin
                pipe_valid_i = 1'b1; pipe_rd_i = 5'(16 + i); pipe_data_i = 32'hB000 + i;
                expect_wr(5'(16 + i), 32'hB000 + i, cyc + 1);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_pipe_only();
        test_bypass();
        test_collision();
        test_aging();
        test_waw_rd0();
        test_reset_mid();
        test_back_to_back();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d outstanding writes required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
